// File: rtl/reorder_buffer_pkg.sv
// Shared sizes and the entry record for the in-order commit buffer.
// DEPTH must be a power of two and at least 2.
package reorder_buffer_pkg;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = $clog2(DEPTH);
    localparam int AREG_W = 4;
    localparam int PREG_W = 4;

    typedef logic [TAG_W-1:0] tag_t;
    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    typedef logic [TAG_W:0]   ptr_t;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] new_preg;
        logic [PREG_W-1:0] old_preg;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback and retire signals of the reorder buffer.
// The master side is dispatch/writeback/renamer; the slave side is the buffer.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    // Allocation uses valid/ready: an entry is taken on a clock edge only when
    // alloc_valid and alloc_ready are both high. The retire side has no ready;
    // every retire_valid pulse must be consumed by the receiver.
    logic              alloc_valid;
    logic              alloc_ready;
    logic [AREG_W-1:0] alloc_areg;
    logic [PREG_W-1:0] alloc_new_preg;
    logic [PREG_W-1:0] alloc_old_preg;
    tag_t              alloc_tag;
    logic              complete_valid;
    tag_t              complete_tag;
    logic              retire_valid;
    logic [PREG_W-1:0] retire_preg;
    logic [AREG_W-1:0] retire_areg;
    logic [PREG_W-1:0] retire_new_preg;
    ptr_t              count;
    logic              empty;
    logic              full;

    modport master (
        output alloc_valid, alloc_areg, alloc_new_preg, alloc_old_preg,
        output complete_valid, complete_tag,
        input  alloc_ready, alloc_tag, retire_valid, retire_preg, retire_areg,
        input  retire_new_preg, count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_areg, alloc_new_preg, alloc_old_preg,
        input  complete_valid, complete_tag,
        output alloc_ready, alloc_tag, retire_valid, retire_preg, retire_areg,
        output retire_new_preg, count, empty, full
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit stage: records renamed destinations at dispatch, marks them
// done on writeback and retires the oldest completed entry once per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic        clk,
    input logic        rst,
    reorder_buffer_if.slave bus
);

    ptr_t       head;
    ptr_t       tail;
    rob_entry_t entries [DEPTH];

    tag_t       head_idx;
    tag_t       tail_idx;
    rob_entry_t head_entry;
    logic       is_full;
    logic       alloc_fire;
    logic       retire_fire;

    assign head_idx   = head[TAG_W-1:0];
    assign tail_idx   = tail[TAG_W-1:0];
    assign head_entry = entries[head_idx];

    assign is_full     = (head[TAG_W] != tail[TAG_W]) && (head_idx == tail_idx);
    assign alloc_fire  = bus.alloc_valid && !is_full;
    // Uses the registered done bit, so a completion arriving this edge retires next edge.
    assign retire_fire = head_entry.valid && head_entry.done;

    assign bus.alloc_ready = !is_full;
    assign bus.alloc_tag   = tail_idx;
    assign bus.count       = tail - head;
    assign bus.empty       = (head == tail);
    assign bus.full        = is_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (alloc_fire)  tail <= tail + ptr_t'(1);
            if (retire_fire) head <= head + ptr_t'(1);
        end
    end

    // Allocation never targets the retiring head (that would need a full buffer),
    // and completion only lands on entries that were already valid before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire && tail_idx == tag_t'(i)) begin
                    entries[i].valid    <= 1'b1;
                    entries[i].done     <= 1'b0;
                    entries[i].areg     <= bus.alloc_areg;
                    entries[i].new_preg <= bus.alloc_new_preg;
                    entries[i].old_preg <= bus.alloc_old_preg;
                end else begin
                    if (bus.complete_valid && bus.complete_tag == tag_t'(i) && entries[i].valid)
                        entries[i].done <= 1'b1;
                    if (retire_fire && head_idx == tag_t'(i))
                        entries[i].valid <= 1'b0;
                end
            end
        end
    end

    // Retire outputs hold their last values between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.retire_valid    <= 1'b0;
            bus.retire_preg     <= '0;
            bus.retire_areg     <= '0;
            bus.retire_new_preg <= '0;
        end else begin
            bus.retire_valid <= retire_fire;
            if (retire_fire) begin
                bus.retire_preg     <= head_entry.old_preg;
                bus.retire_areg     <= head_entry.areg;
                bus.retire_new_preg <= head_entry.new_preg;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, checked
// every cycle against a program-order queue model of the buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk;
    logic rst;
    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int               tag;
        bit               done;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] new_preg;
        logic [PREG_W-1:0] old_preg;
    } m_entry_t;

    m_entry_t          m_q[$];
    logic [PREG_W-1:0] exp_q[$];
    int                m_next_tag;
    bit                m_rv;
    logic [PREG_W-1:0] m_rpreg;
    logic [AREG_W-1:0] m_rareg;
    logic [PREG_W-1:0] m_rnew;

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applied at each rising edge, with the inputs as they stood before it.
    task automatic model_edge();
        bit       acc;
        bit       ret;
        m_entry_t e;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_next_tag = 0;
            m_rv = 0; m_rpreg = '0; m_rareg = '0; m_rnew = '0;
            return;
        end
        acc = bus.alloc_valid && (m_q.size() < DEPTH);
        ret = (m_q.size() > 0) && m_q[0].done;
        if (bus.complete_valid)
            foreach (m_q[i]) if (m_q[i].tag == int'(bus.complete_tag)) m_q[i].done = 1;
        m_rv = ret;
        if (ret) begin
            e = m_q.pop_front();
            m_rpreg = e.old_preg;
            m_rareg = e.areg;
            m_rnew  = e.new_preg;
        end
        if (acc) begin
            e.tag = m_next_tag; e.done = 0;
            e.areg = bus.alloc_areg; e.new_preg = bus.alloc_new_preg; e.old_preg = bus.alloc_old_preg;
            m_q.push_back(e);
            exp_q.push_back(bus.alloc_old_preg);
            m_next_tag = (m_next_tag + 1) % DEPTH;
        end
    endtask

    task automatic compare_all();
        check("retire_valid", bus.retire_valid, m_rv);
        check("retire_preg", bus.retire_preg, m_rpreg);
        check("retire_areg", bus.retire_areg, m_rareg);
        check("retire_new_preg", bus.retire_new_preg, m_rnew);
        check("count", bus.count, m_q.size());
        check("empty", bus.empty, m_q.size() == 0);
        check("full", bus.full, m_q.size() == DEPTH);
        check("alloc_ready", bus.alloc_ready, m_q.size() < DEPTH);
        check("alloc_tag", bus.alloc_tag, m_next_tag);
    endtask

    // Scoreboard on the retire stream: old_preg must come back in allocation order.
    always @(negedge clk) begin
        if (!rst && bus.retire_valid) begin
            if (exp_q.size() == 0) check("retire_spurious", bus.retire_valid, 1'b0);
            else                   check("retire_order", bus.retire_preg, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_alloc(input bit v, input int a, input int n, input int o);
        bus.alloc_valid    = v;
        bus.alloc_areg     = AREG_W'(a);
        bus.alloc_new_preg = PREG_W'(n);
        bus.alloc_old_preg = PREG_W'(o);
    endtask

    task automatic set_complete(input bit v, input int t);
        bus.complete_valid = v;
        bus.complete_tag   = tag_t'(t);
    endtask

    task automatic idle();
        set_alloc(0, 0, 0, 0);
        set_complete(0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        do_reset();
        check("reset_empty", bus.empty, 1'b1);
        check("reset_tag", bus.alloc_tag, 0);

        // Three entries, completed out of order.
        for (int i = 1; i <= 3; i++) begin
            set_alloc(1, i, i + 7, i);
            tick();
        end
        idle();
        check("count3", bus.count, 3);
        for (int t = 2; t >= 0; t--) begin
            set_complete(1, t);
            tick();
        end
        idle();
        for (int k = 0; k < 4; k++) tick();
        check("drain3_empty", bus.empty, 1'b1);

        // Fill to full, push an extra request, free one slot, wrap the tag.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_alloc(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            tick();
        end
        check("full_after_fill", bus.full, 1'b1);
        set_alloc(1, 5, 5, 5);
        set_complete(1, 0);
        tick();
        set_complete(0, 0);
        tick();
        check("wrap_ready", bus.alloc_ready, 1'b1);
        check("wrap_tag", bus.alloc_tag, 0);
        tick();
        idle();

        // Drain to four entries, then alloc on the same edge as a retire.
        for (int t = 1; t <= 4; t++) begin
            set_complete(1, t);
            tick();
        end
        idle();
        for (int k = 0; k < 3; k++) tick();
        check("count4", bus.count, 4);
        set_complete(1, 5);
        tick();
        set_complete(0, 0);
        set_alloc(1, 9, 12, 13);
        tick();
        idle();
        check("same_cycle_count", bus.count, 4);
        check("same_cycle_retire", bus.retire_valid, 1'b1);

        // Completion to an empty slot.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_alloc(1, i + 4, i + 6, i + 11);
            tick();
        end
        idle();
        set_complete(1, 5);
        tick();
        idle();
        tick();
        check("bogus_complete_count", bus.count, 2);
        check("bogus_complete_noretire", bus.retire_valid, 1'b0);

        // Reset with five entries, two of them done but not at the head.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1, i, i + 3, i + 10);
            tick();
        end
        idle();
        set_complete(1, 3); tick();
        set_complete(1, 4); tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_empty", bus.empty, 1'b1);
        check("midreset_noretire", bus.retire_valid, 1'b0);
        for (int k = 0; k < 3; k++) tick();

        // Random traffic with out-of-order completion across many wraps.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 6)
                set_alloc(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            else
                set_alloc(0, 0, 0, 0);
            if (m_q.size() > 0 && $urandom_range(0, 9) < 5)
                set_complete(1, m_q[$urandom_range(0, m_q.size() - 1)].tag);
            else if ($urandom_range(0, 9) < 2)
                set_complete(1, $urandom_range(0, DEPTH - 1));
            else
                set_complete(0, 0);
            tick();
        end
        set_alloc(0, 0, 0, 0);
        for (int k = 0; k < 100 && m_q.size() > 0; k++) begin
            set_complete(1, m_q[$urandom_range(0, m_q.size() - 1)].tag);
            tick();
        end
        idle();
        tick();
        tick();
        check("random_drained", bus.empty, 1'b1);
        check("random_scoreboard", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order commit stage for the out-of-order core: records every renamed destination at dispatch, tracks execution completion, and retires entries strictly in program order. On each retirement it releases the superseded physical register back to the register renamer's free pool (driving the renamer's retire port). It sits between the renamer/dispatch stage and the writeback bus.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2)
- TAG_W, $clog2(DEPTH), entry tag width
- AREG_W, 4, architectural register index width
- PREG_W, 4, physical register index width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  dispatch requests a new entry
- alloc_ready  out  1  entry available (= !full)
- alloc_areg  in  AREG_W  architectural destination
- alloc_new_preg  in  PREG_W  newly allocated physical register
- alloc_old_preg  in  PREG_W  previous mapping of alloc_areg (to be freed at retire)
- alloc_tag  out  TAG_W  tag assigned to the entry accepted this cycle (= tail)
- complete_valid  in  1  writeback reports an entry finished
- complete_tag  in  TAG_W  tag of finished entry
- retire_valid  out  1  one-cycle pulse: head entry retired
- retire_preg  out  PREG_W  old physical register to free (connects to renamer retire index)
- retire_areg  out  AREG_W  architectural register committed
- retire_new_preg  out  PREG_W  committed physical mapping
- count  out  TAG_W+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Circular buffer; head, tail pointers TAG_W+1 bits (extra wrap bit); full when indices equal and wrap bits differ, empty when pointers equal.
- Entry fields: valid, done, areg, new_preg, old_preg.
- Allocate: alloc_valid && alloc_ready at edge → entry[tail] written with done=0, valid=1; tail++.
- Complete: complete_valid at edge and entry[complete_tag].valid → done=1. Completion to an invalid entry is ignored (no state change). Repeated completion harmless.
- Retire: at most one per cycle. At edge, if entry[head].valid && done → valid=0, head++, retire_* registers loaded from the entry, retire_valid=1. Otherwise retire_valid=0 and retire_* hold previous values.
- No backpressure on retire; downstream must accept every pulse.
- alloc_ready depends only on full; a retire in the same cycle does not open a slot until the next cycle.
- Simultaneous alloc and retire: both take effect; count unchanged.
- Simultaneous alloc to tail and completion: completion targeting the tail being allocated this cycle is ignored (entry not valid yet).
- Completion for head in the same edge it is examined: not seen; retire occurs next edge.
- Pointer wrap at DEPTH−1 → 0 with wrap bit toggle.

## Timing
- Reset: head=tail=0, all valid/done=0, retire_valid=0, retire_preg/areg/new_preg=0, count=0, empty=1, full=0, alloc_ready=1, alloc_tag=0. Reset mid-operation discards all entries; no retire pulse issued.
- alloc_tag, alloc_ready, count, empty, full combinational from registered pointers.
- Completion at edge N of an entry at head → retire_valid high in cycle after edge N+1 (2-edge latency).
- Back-to-back completed entries retire one per cycle.
- Entry allocated at edge N and completed at edge N+1 retires at edge N+2 if at head.

## Structure
- rob_pkg: DEPTH/width localparams, rob_entry_t struct {valid, done, areg, new_preg, old_preg}.
- Single module; no sub-module required. Entry array as flops (per-entry valid/done bits must allow independent completion and retire writes).

## Test plan
- Reset, allocate 3 entries (areg 1,2,3; old_preg 1,2,3; new 8,9,10) → tags 0,1,2, count=3; complete tags 2,1,0 in successive cycles → retire pulses in order old_preg 1,2,3, none before tag 0 completes.
- Fill to DEPTH=8 → full=1, alloc_ready=0, 9th alloc_valid ignored; retire one → alloc_ready=1 the following cycle, new tag=0 after wrap.
- Same-cycle alloc and retire at count=4 → count stays 4, both tags/outputs correct.
- complete_valid with tag of empty slot (tag 5 while count=2) → no state change, no retire.
- 20 allocations with completions in random order, steady stream → retire_preg sequence equals allocation order of old_preg exactly, across pointer wrap.
- Reset asserted with 5 entries, 2 done → next cycle empty=1, retire_valid=0, no late retire pulse.
